obstacle_scheduler: RTL and testbench
=====================================

# obstacle_scheduler

Sequencer that owns the obstacle set during gameplay. It picks which obstacle runs next, drives the shared `selected` code and launch pulse seen by every obstacle's `done_in`, and waits for the chosen obstacle's `done`. It inserts a fixed gap between obstacles, guards each run with a watchdog, and reports the round count and win status to the game-state logic. It sits between the menu/game-state control and the bank of obstacle drawing modules.

## Interface
- `NUM_OBSTACLES`, 4: obstacles in the bank. Select codes are 0..NUM_OBSTACLES-1; range 1..16.
- `ROUNDS`, 8: obstacles to complete before `game_won`; range 1..255.
- `GAP_CYCLES`, 32'd65_000_000: idle cycles between obstacles.
- `TIMEOUT_CYCLES`, 32'd650_000_000: watchdog limit per obstacle run.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `play_selected` in 1: level-high while the player is in game.
- `menu_on` in 1: menu displayed; aborts the sequence.
- `done_bus` in NUM_OBSTACLES: bit i is obstacle i's `done` pulse.
- `selected` out 4: select code broadcast to all obstacles. Reset value 0.
- `launch` out 1: single-cycle start pulse, wired to every obstacle's `done_in`. Reset value 0.
- `busy` out 1: high in GAP, LAUNCH and RUN. Reset value 0.
- `round_cnt` out 8: obstacles completed in this game. Reset value 0.
- `timeout_cnt` out 8: watchdog expiries, saturating at 255. Reset value 0.
- `game_won` out 1: level, high in state WON. Reset value 0.

## Operation
- States:
  - IDLE=0: waits for a start; on entry, round_cnt and the counters clear.
  - GAP=1: waits out the inter-obstacle gap.
  - LAUNCH=2: issues the start pulse.
  - RUN=3: waits for the selected obstacle to finish.
  - WON=4: game complete.
- IDLE→GAP when `play_selected && !menu_on`. Cycle counter loads 0.
- GAP: counter increments each cycle. When counter == GAP_CYCLES-1, `selected` loads the next code and the state goes to LAUNCH.
- LAUNCH: `launch`=1 for exactly this one cycle, watchdog loads 0, then RUN.
- RUN: `selected` is held constant. Only `done_bus[selected]` is honoured; all other bits are ignored.
  - On `done_bus[selected]`: round_cnt+1. If the new value == ROUNDS, go to WON; else go to GAP.
  - Watchdog reaching TIMEOUT_CYCLES-1: timeout_cnt+1 (saturating), round_cnt unchanged, go to GAP.
  - If done and the watchdog limit land on the same cycle, done wins and no timeout is counted.
- WON: `game_won`=1. Stays until `!play_selected || menu_on`, then IDLE.
- Abort: in any non-IDLE state, `menu_on` or `!play_selected` forces IDLE next cycle. `launch`=0 and `selected` retains its value.
- Next-code rule, round-robin (default): `selected` = (selected+1) mod NUM_OBSTACLES. The first pick after IDLE is code 0.
- `done_bus` bits arriving while not in RUN are ignored.
- Counter widths: 32-bit cycle counter and watchdog. round_cnt is 8-bit.
- `busy` = (state ∈ {GAP, LAUNCH, RUN}), registered.

## Timing
- All outputs are registered. Asynchronous reset clears them immediately on `rst_n` low, and the state goes to IDLE.
- A reset asserted mid-RUN drops `launch`/`busy` at once. Obstacles rely on their own reset.
- Start asserted at edge N: GAP from N+1. `launch` is high during cycle N+1+GAP_CYCLES, with the new `selected` already valid that cycle.
- Done sampled at edge M: round_cnt is updated and the state is GAP/WON at M+1.
- Abort sampled at edge K: IDLE at K+1.

## Configuration
- `OBSTACLE_SCHED_RANDOM_EN` defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) free-runs every cycle.
  - The next code is lfsr[3:0] mod NUM_OBSTACLES. If that equals the previous code, it is incremented mod NUM_OBSTACLES, so there are no back-to-back repeats when NUM_OBSTACLES>1.
  - The first pick is also from the LFSR.
- Undefined: round-robin as above, and no LFSR is instantiated.

## Test plan
All scenarios use NUM_OBSTACLES=4, ROUNDS=3, GAP_CYCLES=10, TIMEOUT_CYCLES=50, with the macro undefined unless stated.
1. Nominal: raise play_selected; pulse done_bus[selected] 5 cycles after each launch → launches carry selected=0,1,2; round_cnt 1,2,3; game_won=1 after the third done; busy=0 in WON.
2. Wrong done: in RUN with selected=1, pulse done_bus[2] → no state change, round_cnt unchanged; a later done_bus[1] is accepted.
3. Timeout: never pulse done → RUN exits after 50 cycles; timeout_cnt=1; round_cnt=0; next launch has selected=1.
4. Abort: assert menu_on during GAP and again during RUN → IDLE next cycle, launch stays 0; a restart launches selected=0 with round_cnt=0.
5. Reset mid-RUN: drop rst_n asynchronously → all outputs 0 before the next clock edge; after release, the state is IDLE.
6. With `OBSTACLE_SCHED_RANDOM_EN` defined: 20 launches → every selected <4, no two consecutive codes equal, and the sequence is identical across two runs from reset.

Source files
------------

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: sequences obstacle runs during gameplay.
// Picks the next obstacle, broadcasts its select code with a one-cycle
// launch pulse, waits for that obstacle's done (guarded by a watchdog),
// inserts a fixed gap between runs, and reports round/timeout counts and win.
// Optional feature: define OBSTACLE_SCHED_RANDOM_EN to pick codes from a
// free-running 16-bit Galois LFSR instead of round-robin.
module obstacle_scheduler #(
    parameter int          NUM_OBSTACLES  = 4,
    parameter int          ROUNDS         = 8,
    parameter logic [31:0] GAP_CYCLES     = 32'd65_000_000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd650_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     play_selected,
    input  logic                     menu_on,
    input  logic [NUM_OBSTACLES-1:0] done_bus,
    output logic [3:0]               selected,
    output logic                     launch,
    output logic                     busy,
    output logic [7:0]               round_cnt,
    output logic [7:0]               timeout_cnt,
    output logic                     game_won
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GAP    = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        WON    = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] wd;
    logic        first;   // next pick is the first one since leaving IDLE
    logic        abort;
    logic        done_sel;
    logic [3:0]  nxt;

    assign abort    = menu_on || !play_selected;
    // only the currently selected obstacle's done bit counts
    assign done_sel = |(done_bus & (NUM_OBSTACLES'(1) << selected));

`ifdef OBSTACLE_SCHED_RANDOM_EN
    logic [15:0] lfsr;
    logic [4:0]  r5;

    // free-running right-shift Galois LFSR, taps 16,14,13,11
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // random pick, bumped by one when it would repeat the previous code
    always_comb begin
        r5 = {1'b0, lfsr[3:0]} % 5'(NUM_OBSTACLES);
        if (!first && r5[3:0] == selected) r5 = (r5 + 5'd1) % 5'(NUM_OBSTACLES);
        nxt = r5[3:0];
    end
`else
    // round-robin pick, restarting at code 0 after IDLE
    always_comb begin
        nxt = 4'd0;
        if (!first && selected != 4'(NUM_OBSTACLES - 1)) nxt = selected + 4'd1;
    end
`endif

    // sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 32'd0;
            wd          <= 32'd0;
            first       <= 1'b1;
            selected    <= 4'd0;
            launch      <= 1'b0;
            busy        <= 1'b0;
            round_cnt   <= 8'd0;
            timeout_cnt <= 8'd0;
            game_won    <= 1'b0;
        end else begin
            launch <= 1'b0;
            if (state != IDLE && abort) begin
                // abort (also the normal WON exit): selected is kept
                state       <= IDLE;
                busy        <= 1'b0;
                game_won    <= 1'b0;
                cnt         <= 32'd0;
                wd          <= 32'd0;
                round_cnt   <= 8'd0;
                timeout_cnt <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!abort) begin
                            state <= GAP;
                            busy  <= 1'b1;
                            cnt   <= 32'd0;
                            first <= 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt == GAP_CYCLES - 32'd1) begin
                            selected <= nxt;
                            first    <= 1'b0;
                            launch   <= 1'b1;
                            state    <= LAUNCH;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    LAUNCH: begin
                        wd    <= 32'd0;
                        state <= RUN;
                    end
                    RUN: begin
                        // done beats a watchdog expiry on the same cycle
                        if (done_sel) begin
                            round_cnt <= round_cnt + 8'd1;
                            cnt       <= 32'd0;
                            if ((round_cnt + 8'd1) == 8'(ROUNDS)) begin
                                state    <= WON;
                                game_won <= 1'b1;
                                busy     <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
                        end else if (wd == TIMEOUT_CYCLES - 32'd1) begin
                            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
                            cnt   <= 32'd0;
                            state <= GAP;
                        end else begin
                            wd <= wd + 32'd1;
                        end
                    end
                    WON: begin
                        game_won <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Testbench for obstacle_scheduler: scenario tasks with a scoreboard queue of
// expected select codes, popped whenever a launch pulse is observed.
module tb_obstacle_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       play_selected = 1'b0;
    logic       menu_on = 1'b0;
    logic [3:0] done_bus = 4'd0;
    logic [3:0] selected;
    logic       launch;
    logic       busy;
    logic [7:0] round_cnt;
    logic [7:0] timeout_cnt;
    logic       game_won;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] exp_q[$];

    obstacle_scheduler #(
        .NUM_OBSTACLES (4),
        .ROUNDS        (3),
        .GAP_CYCLES    (32'd10),
        .TIMEOUT_CYCLES(32'd50)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .play_selected(play_selected),
        .menu_on      (menu_on),
        .done_bus     (done_bus),
        .selected     (selected),
        .launch       (launch),
        .busy         (busy),
        .round_cnt    (round_cnt),
        .timeout_cnt  (timeout_cnt),
        .game_won     (game_won)
    );

    always #5 clk = ~clk;

    // waits (bounded) for a launch pulse, sampling on negedges
    task automatic wait_launch(input int budget, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (launch) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if ({selected, launch, busy, round_cnt, timeout_cnt, game_won} !== 23'd0) begin n_err++; $display("FAIL reset_outputs: got sel=%0d launch=%b busy=%b round=%0d to=%0d won=%b, want all 0", selected, launch, busy, round_cnt, timeout_cnt, game_won); end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || launch !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b launch=%b, want 0 0", busy, launch); end
    endtask

    task automatic test_nominal();
        bit ok; int cyc; logic [3:0] e;
        exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2);
        play_selected = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            wait_launch(40, ok, cyc);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL nom_launch_wait: no launch for round %0d, want launch", r); end
            e = exp_q.pop_front();
            n_cmp++; if (selected !== e) begin n_err++; $display("FAIL nom_sel: got %0d want %0d", selected, e); end
            if (r == 1) begin
                n_cmp++; if (cyc != 11) begin n_err++; $display("FAIL nom_latency: got %0d cycles want 11", cyc); end
            end
            @(negedge clk);
            n_cmp++; if (launch !== 1'b0) begin n_err++; $display("FAIL nom_pulse_width: launch=%b want 0", launch); end
            repeat (4) @(negedge clk);
            done_bus = 4'b0001 << selected;
            @(negedge clk);
            done_bus = 4'd0;
            n_cmp++; if (round_cnt !== 8'(r)) begin n_err++; $display("FAIL nom_round: got %0d want %0d", round_cnt, r); end
        end
        n_cmp++; if (game_won !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL nom_won: won=%b busy=%b want 1 0", game_won, busy); end
        repeat (5) @(negedge clk);
        n_cmp++; if (game_won !== 1'b1 || launch !== 1'b0) begin n_err++; $display("FAIL nom_won_hold: won=%b launch=%b want 1 0", game_won, launch); end
        play_selected = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (game_won !== 1'b0 || round_cnt !== 8'd0) begin n_err++; $display("FAIL nom_won_exit: won=%b round=%0d want 0 0", game_won, round_cnt); end
    endtask

    task automatic test_wrong_done();
        bit ok; int cyc; logic [3:0] e;
        exp_q.push_back(4'd0); exp_q.push_back(4'd1);
        play_selected = 1'b1;
        wait_launch(40, ok, cyc);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || selected !== e) begin n_err++; $display("FAIL wd_sel0: ok=%b got %0d want %0d", ok, selected, e); end
        repeat (3) @(negedge clk);
        done_bus = 4'b0001;
        @(negedge clk);
        done_bus = 4'd0;
        wait_launch(40, ok, cyc);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || selected !== e) begin n_err++; $display("FAIL wd_sel1: ok=%b got %0d want %0d", ok, selected, e); end
        repeat (3) @(negedge clk);
        done_bus = 4'b0100;
        @(negedge clk);
        done_bus = 4'd0;
        n_cmp++; if (round_cnt !== 8'd1 || busy !== 1'b1) begin n_err++; $display("FAIL wd_ignored: round=%0d busy=%b want 1 1", round_cnt, busy); end
        repeat (2) @(negedge clk);
        n_cmp++; if (round_cnt !== 8'd1 || launch !== 1'b0) begin n_err++; $display("FAIL wd_still_run: round=%0d launch=%b want 1 0", round_cnt, launch); end
        done_bus = 4'b0010;
        @(negedge clk);
        done_bus = 4'd0;
        n_cmp++; if (round_cnt !== 8'd2) begin n_err++; $display("FAIL wd_accept: round=%0d want 2", round_cnt); end
        play_selected = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok; int cyc; logic [3:0] e;
        exp_q.push_back(4'd0); exp_q.push_back(4'd1);
        play_selected = 1'b1;
        wait_launch(40, ok, cyc);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || selected !== e) begin n_err++; $display("FAIL to_sel0: ok=%b got %0d want %0d", ok, selected, e); end
        repeat (50) @(negedge clk);
        n_cmp++; if (timeout_cnt !== 8'd0) begin n_err++; $display("FAIL to_early: timeout_cnt=%0d want 0 after 49 RUN cycles", timeout_cnt); end
        @(negedge clk);
        n_cmp++; if (timeout_cnt !== 8'd1 || round_cnt !== 8'd0 || busy !== 1'b1) begin n_err++; $display("FAIL to_expire: to=%0d round=%0d busy=%b want 1 0 1", timeout_cnt, round_cnt, busy); end
        wait_launch(40, ok, cyc);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || selected !== e || cyc != 10) begin n_err++; $display("FAIL to_next: ok=%b sel=%0d cyc=%0d want sel %0d cyc 10", ok, selected, cyc, e); end
        play_selected = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        bit ok; int cyc; bit seen; logic [3:0] e;
        play_selected = 1'b1;
        repeat (3) @(negedge clk);
        menu_on = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ab_gap: busy=%b want 0", busy); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin @(negedge clk); if (launch) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL ab_gap_nolaunch: launch seen=%b want 0", seen); end
        menu_on = 1'b0;
        exp_q.push_back(4'd0); exp_q.push_back(4'd1);
        wait_launch(40, ok, cyc);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || selected !== e) begin n_err++; $display("FAIL ab_sel0: ok=%b got %0d want %0d", ok, selected, e); end
        repeat (3) @(negedge clk);
        done_bus = 4'b0001;
        @(negedge clk);
        done_bus = 4'd0;
        wait_launch(40, ok, cyc);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || selected !== e) begin n_err++; $display("FAIL ab_sel1: ok=%b got %0d want %0d", ok, selected, e); end
        repeat (2) @(negedge clk);
        menu_on = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || launch !== 1'b0 || selected !== 4'd1) begin n_err++; $display("FAIL ab_run: busy=%b launch=%b sel=%0d want 0 0 1", busy, launch, selected); end
        repeat (3) @(negedge clk);
        menu_on = 1'b0;
        exp_q.push_back(4'd0);
        wait_launch(40, ok, cyc);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || selected !== e || round_cnt !== 8'd0) begin n_err++; $display("FAIL ab_restart: ok=%b sel=%0d round=%0d want sel %0d round 0", ok, selected, round_cnt, e); end
        play_selected = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_run();
        bit ok; int cyc; logic [3:0] e;
        exp_q.push_back(4'd0); exp_q.push_back(4'd1);
        play_selected = 1'b1;
        wait_launch(40, ok, cyc);
        e = exp_q.pop_front();
        repeat (3) @(negedge clk);
        done_bus = 4'b0001;
        @(negedge clk);
        done_bus = 4'd0;
        wait_launch(40, ok, cyc);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || selected !== e) begin n_err++; $display("FAIL rr_sel1: ok=%b got %0d want %0d", ok, selected, e); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({selected, launch, busy, round_cnt, timeout_cnt, game_won} !== 23'd0) begin n_err++; $display("FAIL rr_async: sel=%0d launch=%b busy=%b round=%0d to=%0d won=%b want all 0", selected, launch, busy, round_cnt, timeout_cnt, game_won); end
        play_selected = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle: busy=%b want 0", busy); end
        play_selected = 1'b1;
        exp_q.push_back(4'd0);
        wait_launch(40, ok, cyc);
        e = exp_q.pop_front();
        n_cmp++; if (!ok || selected !== e || cyc != 11) begin n_err++; $display("FAIL rr_restart: ok=%b sel=%0d cyc=%0d want sel %0d cyc 11", ok, selected, cyc, e); end
        play_selected = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        bit ok; int cyc; logic [3:0] code; logic [3:0] prev; logic [3:0] e;
        for (int run = 0; run < 2; run++) begin
            play_selected = 1'b0;
            @(negedge clk) rst_n = 1'b0;
            @(negedge clk) rst_n = 1'b1;
            @(negedge clk) play_selected = 1'b1;
            prev = 4'hF;
            for (int i = 0; i < 20; i++) begin
                wait_launch(100, ok, cyc);
                n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_wait: no launch run %0d idx %0d", run, i); end
                code = selected;
                n_cmp++; if (code >= 4'd4) begin n_err++; $display("FAIL rnd_range: code=%0d want <4", code); end
                if (i > 0) begin
                    n_cmp++; if (code === prev) begin n_err++; $display("FAIL rnd_repeat: code=%0d equals previous %0d", code, prev); end
                end
                if (run == 0) exp_q.push_back(code);
                else begin
                    e = exp_q.pop_front();
                    n_cmp++; if (code !== e) begin n_err++; $display("FAIL rnd_replay: idx %0d got %0d want %0d", i, code, e); end
                end
                prev = code;
            end
        end
        play_selected = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
`ifdef OBSTACLE_SCHED_RANDOM_EN
        test_random();
`else
        test_nominal();
        test_wrong_done();
        test_timeout();
        test_abort();
        test_reset_run();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
